// File: rtl/sha256_msg_pad.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sha256_msg_pad                                               |
// | Description : Message padding front end for a SHA-256 scheduler. Accepts a |
// |               32-bit big-endian word stream, applies the 0x80 marker, the  |
// |               zero fill and the 64-bit bit-length field, and buffers each  |
// |               512-bit block. Each block is replayed as 16 back-to-back     |
// |               words on ld_o/M_o. After each burst there is a gap of        |
// |               EXP_CYCLES cycles with ld_o low while the scheduler expands. |
// | Ports       : clk, rst_n (async, active low)                               |
// |               in_valid_i/in_ready_o/in_data_i/in_last_i/in_bytes_i         |
// |                 - input message stream, byte 0 in [31:24]                  |
// |               blk_ready_i - downstream can accept a new block              |
// |               ld_o/M_o    - word-load strobe and word to scheduler         |
// |               blk_first_o - word 0 of every block                          |
// |               blk_last_o  - all 16 words of the final block of a message   |
// | Options     : define SHA256_PAD_RAW_EN to add input raw_i. raw_i is        |
// |               sampled with the first word of a message. When it is 1, the  |
// |               message is sent without the marker or the length field.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sha256_msg_pad #(
  parameter int EXP_CYCLES = 48,
  parameter int LEN_W      = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_data_i,
  input  logic        in_last_i,
  input  logic [2:0]  in_bytes_i,
`ifdef SHA256_PAD_RAW_EN
  input  logic        raw_i,
`endif
  input  logic        blk_ready_i,
  output logic        ld_o,
  output logic [31:0] M_o,
  output logic        blk_first_o,
  output logic        blk_last_o
);

  localparam int          c_EXP_W  = (EXP_CYCLES > 0) ? $clog2(EXP_CYCLES + 1) : 1;
  localparam logic [31:0] c_MARKER = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_PAD  = 2'd1,
    S_SEND = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [31:0]          r_buf [16];
  logic [4:0]           r_widx;      // 0..16; 16 means buffer full
  logic [LEN_W-1:0]     r_len;
  logic                 r_pend;      // 0x80000000 still has to be written
  logic                 r_xtra;      // marker fell into word 14/15: need a length-only block
  logic                 r_final;     // buffered block is the last one of its message
  logic                 r_live;      // first clock after reset has happened
  logic                 r_sending;
  logic [3:0]           r_cnt;
  logic [c_EXP_W-1:0]   r_exp;

  logic                 w_hs;
  logic                 w_raw;
  logic                 w_start;
  logic                 w_send_done;
  logic                 w_widx_hi;
  logic [2:0]           w_bytes;
  logic [31:0]          w_tail_word;
  logic [63:0]          w_len64;
  logic [3:0]           w_rd_idx;

  logic                 w_wr_en;
  logic [31:0]          w_wr_data;
  logic [4:0]           w_widx_nxt;
  logic [LEN_W-1:0]     w_len_nxt;
  logic                 w_pend_nxt;
  logic                 w_xtra_nxt;
  logic                 w_final_nxt;

  // --------------------------------------------------------------------------
  // Raw (unpadded) mode
  // --------------------------------------------------------------------------
`ifdef SHA256_PAD_RAW_EN
  logic r_first;   // next accepted word starts a new message
  logic r_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_first <= 1'b1;
      r_raw   <= 1'b0;
    end else if (w_hs) begin
      r_first <= in_last_i;
      if (r_first) begin
        r_raw <= raw_i;
      end
    end
  end

  // raw_i applies to the first word itself, so bypass the register on that word.
  assign w_raw = (r_state == S_FILL && r_first) ? raw_i : r_raw;
`else
  assign w_raw = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Handshake and helpers
  // --------------------------------------------------------------------------
  assign in_ready_o  = r_live && (r_state == S_FILL) && !r_widx[4];
  assign w_hs        = in_valid_i && in_ready_o;
  assign w_widx_hi   = !r_widx[4] && (r_widx[3:1] == 3'b111);
  // Only a last word may be partial; anything above 4 is also treated as 4.
  assign w_bytes     = (!in_last_i || in_bytes_i > 3'd4) ? 3'd4 : in_bytes_i;
  assign w_start     = (r_state == S_SEND) && !r_sending && (r_exp == '0) && blk_ready_i;
  assign w_send_done = r_sending && (r_cnt == 4'd15);

  // Partial last word: keep the valid bytes, place the marker right after them.
  always_comb begin
    w_tail_word = c_MARKER;
    case (in_bytes_i)
      3'd1:    w_tail_word = {in_data_i[31:24], 8'h80, 16'h0000};
      3'd2:    w_tail_word = {in_data_i[31:16], 8'h80, 8'h00};
      3'd3:    w_tail_word = {in_data_i[31:8], 8'h80};
      default: w_tail_word = c_MARKER;
    endcase
  end

  generate
    if (LEN_W >= 64) begin : g_len_full
      assign w_len64 = r_len[63:0];
    end else begin : g_len_ext
      assign w_len64 = {{(64 - LEN_W){1'b0}}, r_len};
    end
  endgenerate

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and buffer write control
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_wr_data   = 32'h0;
    w_widx_nxt  = r_widx;
    w_len_nxt   = r_len;
    w_pend_nxt  = r_pend;
    w_xtra_nxt  = r_xtra;
    w_final_nxt = r_final;

    case (r_state)
      S_FILL: begin
        if (w_hs) begin
          w_wr_en    = 1'b1;
          w_wr_data  = in_data_i;
          w_widx_nxt = r_widx + 5'd1;
          w_len_nxt  = r_len + (LEN_W'(w_bytes) << 3);
          if (in_last_i) begin
            if (w_raw) begin
              if (r_widx[3:0] == 4'd15) begin
                w_state_nxt = S_SEND;
                w_final_nxt = 1'b1;
                w_xtra_nxt  = 1'b0;
              end else begin
                w_state_nxt = S_PAD;
              end
            end else begin
              w_state_nxt = S_PAD;
              if (w_bytes == 3'd4) begin
                w_pend_nxt = 1'b1;
              end else begin
                w_wr_data  = w_tail_word;
                w_pend_nxt = 1'b0;
              end
              // Anything the marker occupies in word 14/15 leaves no room for the length.
              w_xtra_nxt = w_widx_hi;
            end
          end else if (r_widx[3:0] == 4'd15) begin
            w_state_nxt = S_SEND;
            w_final_nxt = 1'b0;
          end
        end
      end

      S_PAD: begin
        if (r_widx[4]) begin
          // Last word filled the block; the marker and the length go into the next one.
          w_state_nxt = S_SEND;
          w_final_nxt = w_raw;
          w_xtra_nxt  = !w_raw;
        end else begin
          w_wr_en    = 1'b1;
          w_widx_nxt = r_widx + 5'd1;
          if (w_raw) begin
            w_wr_data = 32'h0;
            w_xtra_nxt = 1'b0;
          end else if (r_pend) begin
            w_wr_data  = c_MARKER;
            w_pend_nxt = 1'b0;
            if (w_widx_hi) begin
              w_xtra_nxt = 1'b1;
            end
          end else if (!w_widx_hi || r_xtra) begin
            w_wr_data = 32'h0;
          end else if (r_widx[0] == 1'b0) begin
            w_wr_data = w_len64[63:32];
          end else begin
            w_wr_data = w_len64[31:0];
          end
          if (r_widx[3:0] == 4'd15) begin
            w_state_nxt = S_SEND;
            w_final_nxt = !w_xtra_nxt;
          end
        end
      end

      S_SEND: begin
        if (w_send_done) begin
          w_widx_nxt = 5'd0;
          if (r_final) begin
            w_len_nxt = '0;
          end
          if (r_xtra) begin
            w_state_nxt = S_PAD;
            w_xtra_nxt  = 1'b0;
          end else begin
            w_state_nxt = S_FILL;
          end
        end
      end

      default: begin
        w_state_nxt = S_FILL;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Buffer, counters and message length
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        r_buf[i] <= 32'h0;
      end
      r_widx  <= 5'd0;
      r_len   <= '0;
      r_pend  <= 1'b0;
      r_xtra  <= 1'b0;
      r_final <= 1'b0;
      r_live  <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_buf[r_widx[3:0]] <= w_wr_data;
      end
      r_widx  <= w_widx_nxt;
      r_len   <= w_len_nxt;
      r_pend  <= w_pend_nxt;
      r_xtra  <= w_xtra_nxt;
      r_final <= w_final_nxt;
      r_live  <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Burst sequencer and expansion gap
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sending <= 1'b0;
      r_cnt     <= 4'd0;
      r_exp     <= '0;
    end else begin
      if (w_start) begin
        r_sending <= 1'b1;
        r_cnt     <= 4'd1;
      end else if (w_send_done) begin
        r_sending <= 1'b0;
        r_cnt     <= 4'd0;
      end else if (r_sending) begin
        r_cnt <= r_cnt + 4'd1;
      end

      if (w_send_done) begin
        r_exp <= c_EXP_W'(EXP_CYCLES);
      end else if (r_exp != '0) begin
        r_exp <= r_exp - 1'b1;
      end
    end
  end

  // Word 0 goes out combinationally in the start cycle. This keeps the burst
  // pitch at exactly 16 + EXP_CYCLES.
  assign w_rd_idx    = r_sending ? r_cnt : 4'd0;
  assign ld_o        = w_start || r_sending;
  assign M_o         = ld_o ? r_buf[w_rd_idx] : 32'h0;
  assign blk_first_o = w_start;
  assign blk_last_o  = ld_o && r_final;

endmodule
`default_nettype wire

// File: tb/tb_sha256_msg_pad.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sha256_msg_pad                                            |
// | Description : Self-checking bench for sha256_msg_pad. Expected bursts come |
// |               from a byte-level FIPS-180-4 padding model.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sha256_msg_pad;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid_i = 1'b0;
  logic [31:0] in_data_i = 32'h0;
  logic        in_last_i = 1'b0;
  logic [2:0]  in_bytes_i = 3'd0;
  logic        blk_ready_i = 1'b1;
  logic        in_ready_o;
  logic        ld_o;
  logic [31:0] M_o;
  logic        blk_first_o;
  logic        blk_last_o;

  sha256_msg_pad #(.EXP_CYCLES(48), .LEN_W(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .in_last_i   (in_last_i),
    .in_bytes_i  (in_bytes_i),
    .blk_ready_i (blk_ready_i),
    .ld_o        (ld_o),
    .M_o         (M_o),
    .blk_first_o (blk_first_o),
    .blk_last_o  (blk_last_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Capture of every ld_o cycle.
  logic [31:0] cap_w[$];
  logic        cap_f[$];
  logic        cap_l[$];
  int          cap_t[$];

  always @(negedge clk) begin
    if (ld_o) begin
      cap_w.push_back(M_o);
      cap_f.push_back(blk_first_o);
      cap_l.push_back(blk_last_o);
      cap_t.push_back(cyc);
    end
  end

  byte unsigned msg[$];
  logic [31:0]  exp_w[$];
  logic         exp_f[$];
  logic         exp_l[$];
  int n_pass = 0;
  int n_total = 0;

  // Pad the message at byte level, then cut it into words and blocks.
  task automatic build_exp();
    byte unsigned p[$];
    logic [63:0]  bits;
    int           nw;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bits = 64'(msg.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(8'(bits >> (8 * i)));
    exp_w.delete(); exp_f.delete(); exp_l.delete();
    nw = p.size() / 4;
    for (int k = 0; k < nw; k++) begin
      exp_w.push_back({p[4*k], p[4*k+1], p[4*k+2], p[4*k+3]});
      exp_f.push_back((k % 16) == 0);
      exp_l.push_back(k >= nw - 16);
    end
  endtask

  task automatic clear_cap();
    cap_w.delete(); cap_f.delete(); cap_l.delete(); cap_t.delete();
  endtask

  // Drive msg as words; unused low bytes of a partial word carry random junk.
  task automatic drive_msg(input bit gaps, output bit ok);
    int n;
    n  = (msg.size() == 0) ? 1 : (msg.size() + 3) / 4;
    ok = 1'b1;
    for (int k = 0; k < n; k++) begin
      logic [31:0] w;
      int          nb;
      int          budget;
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      w  = $urandom;
      nb = msg.size() - 4 * k;
      if (nb > 4) nb = 4;
      for (int b = 0; b < nb; b++) w[31 - 8*b -: 8] = msg[4*k + b];
      in_valid_i = 1'b1;
      in_data_i  = w;
      in_bytes_i = 3'(nb);
      in_last_i  = (k == n - 1);
      budget = 0;
      while (!in_ready_o && budget < 3000) begin
        @(negedge clk);
        budget++;
      end
      if (!in_ready_o) begin
        ok = 1'b0;
        break;
      end
      @(negedge clk);
      in_valid_i = 1'b0;
    end
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  task automatic wait_words(input int n, output bit ok);
    int budget;
    budget = 0;
    while (cap_w.size() < n && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    ok = (cap_w.size() >= n);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({in_ready_o, ld_o, M_o, blk_first_o, blk_last_o} !== 36'h0)
      $display("FAIL reset_outputs: ready=%b ld=%b M=%h first=%b last=%b, required all 0",
               in_ready_o, ld_o, M_o, blk_first_o, blk_last_o);
    else n_pass++;
    in_valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_total++;
    if (in_ready_o !== 1'b1) $display("FAIL reset_ready: in_ready_o=%b, required 1", in_ready_o);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_abc();
    bit ok1, ok2;
    msg = '{8'h61, 8'h62, 8'h63};
    build_exp(); clear_cap();
    drive_msg(1'b0, ok1);
    wait_words(exp_w.size(), ok2);
    n_total++;
    if (!(ok1 && ok2) || cap_w.size() != 16) $display("FAIL abc_count: got %0d words, required 16", cap_w.size());
    else n_pass++;
    for (int k = 0; k < exp_w.size() && k < cap_w.size(); k++) begin
      n_total++;
      if ({cap_w[k], cap_f[k], cap_l[k]} !== {exp_w[k], exp_f[k], exp_l[k]})
        $display("FAIL abc_word%0d: got %h/%b/%b, required %h/%b/%b", k, cap_w[k], cap_f[k], cap_l[k], exp_w[k], exp_f[k], exp_l[k]);
      else n_pass++;
    end
    if (cap_w.size() >= 16) begin
      n_total++;
      if (cap_w[0] !== 32'h61626380 || cap_w[15] !== 32'h00000018 || cap_t[15] - cap_t[0] != 15)
        $display("FAIL abc_literal: w0=%h w15=%h span=%0d, required 61626380 00000018 15", cap_w[0], cap_w[15], cap_t[15] - cap_t[0]);
      else n_pass++;
    end
  endtask

  task automatic test_empty();
    bit ok1, ok2;
    msg.delete();
    build_exp(); clear_cap();
    drive_msg(1'b0, ok1);
    wait_words(exp_w.size(), ok2);
    n_total++;
    if (!(ok1 && ok2) || cap_w.size() != 16) $display("FAIL empty_count: got %0d words, required 16", cap_w.size());
    else n_pass++;
    for (int k = 0; k < exp_w.size() && k < cap_w.size(); k++) begin
      n_total++;
      if ({cap_w[k], cap_f[k], cap_l[k]} !== {exp_w[k], exp_f[k], exp_l[k]})
        $display("FAIL empty_word%0d: got %h/%b/%b, required %h/%b/%b", k, cap_w[k], cap_f[k], cap_l[k], exp_w[k], exp_f[k], exp_l[k]);
      else n_pass++;
    end
  endtask

  task automatic test_55_56(input int len);
    bit ok1, ok2;
    msg.delete();
    for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
    build_exp(); clear_cap();
    drive_msg(1'b0, ok1);
    wait_words(exp_w.size(), ok2);
    n_total++;
    if (!(ok1 && ok2) || cap_w.size() != exp_w.size())
      $display("FAIL len%0d_count: got %0d words, required %0d", len, cap_w.size(), exp_w.size());
    else n_pass++;
    for (int k = 0; k < exp_w.size() && k < cap_w.size(); k++) begin
      n_total++;
      if ({cap_w[k], cap_f[k], cap_l[k]} !== {exp_w[k], exp_f[k], exp_l[k]})
        $display("FAIL len%0d_word%0d: got %h/%b/%b, required %h/%b/%b", len, k, cap_w[k], cap_f[k], cap_l[k], exp_w[k], exp_f[k], exp_l[k]);
      else n_pass++;
    end
    if (len == 55 && cap_w.size() >= 16) begin
      n_total++;
      if (cap_w[15] !== 32'h000001B8 || cap_w[13][7:0] !== 8'h80)
        $display("FAIL len55_literal: w13=%h w15=%h, required byte3=80 and 000001b8", cap_w[13], cap_w[15]);
      else n_pass++;
    end
    if (len == 56 && cap_w.size() >= 32) begin
      n_total++;
      if (cap_w[14] !== 32'h80000000 || cap_w[31] !== 32'h000001C0 || cap_l[0] !== 1'b0 || cap_l[16] !== 1'b1)
        $display("FAIL len56_literal: w14=%h w31=%h last0=%b last16=%b, required 80000000 000001c0 0 1",
                 cap_w[14], cap_w[31], cap_l[0], cap_l[16]);
      else n_pass++;
      n_total++;
      if (cap_t[16] - cap_t[0] != 64 || cap_t[31] - cap_t[16] != 15)
        $display("FAIL len56_pitch: pitch=%0d span=%0d, required 64 15", cap_t[16] - cap_t[0], cap_t[31] - cap_t[16]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int m = 0; m < 6; m++) begin
      bit ok1, ok2;
      int len;
      int bad;
      len = $urandom_range(0, 150);
      msg.delete();
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
      build_exp(); clear_cap();
      drive_msg(1'b1, ok1);
      wait_words(exp_w.size(), ok2);
      repeat (80) @(negedge clk);
      n_total++;
      if (!(ok1 && ok2) || cap_w.size() != exp_w.size())
        $display("FAIL rand%0d_count: len=%0d got %0d words, required %0d", m, len, cap_w.size(), exp_w.size());
      else n_pass++;
      bad = -1;
      for (int k = 0; k < exp_w.size() && k < cap_w.size(); k++)
        if (bad < 0 && {cap_w[k], cap_f[k], cap_l[k]} !== {exp_w[k], exp_f[k], exp_l[k]}) bad = k;
      n_total++;
      if (bad >= 0)
        $display("FAIL rand%0d_words: len=%0d word%0d got %h/%b/%b, required %h/%b/%b", m, len, bad,
                 cap_w[bad], cap_f[bad], cap_l[bad], exp_w[bad], exp_f[bad], exp_l[bad]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    bit ok1, ok2;
    repeat (70) @(negedge clk);
    msg.delete();
    for (int i = 0; i < 128; i++) msg.push_back(8'($urandom));
    build_exp(); clear_cap();
    blk_ready_i = 1'b0;
    fork
      drive_msg(1'b0, ok1);
      begin
        repeat (100) @(negedge clk);
        n_total++;
        if (cap_w.size() != 0 || in_ready_o !== 1'b0)
          $display("FAIL bp_hold: words=%0d in_ready=%b, required 0 0", cap_w.size(), in_ready_o);
        else n_pass++;
        blk_ready_i = 1'b1;
      end
    join
    wait_words(exp_w.size(), ok2);
    n_total++;
    if (!(ok1 && ok2) || cap_w.size() != exp_w.size())
      $display("FAIL bp_count: got %0d words, required %0d", cap_w.size(), exp_w.size());
    else n_pass++;
    for (int k = 0; k < exp_w.size() && k < cap_w.size(); k++) begin
      n_total++;
      if ({cap_w[k], cap_f[k], cap_l[k]} !== {exp_w[k], exp_f[k], exp_l[k]})
        $display("FAIL bp_word%0d: got %h/%b/%b, required %h/%b/%b", k, cap_w[k], cap_f[k], cap_l[k], exp_w[k], exp_f[k], exp_l[k]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    bit ok1, ok2;
    int seen;
    int budget;
    repeat (70) @(negedge clk);
    msg.delete();
    for (int i = 0; i < 20; i++) msg.push_back(8'($urandom));
    clear_cap();
    drive_msg(1'b0, ok1);
    seen = 0;
    budget = 0;
    while (seen < 8 && budget < 500) begin
      @(posedge clk);
      #2;
      if (ld_o) seen++;
      budget++;
    end
    n_total++;
    if (seen != 8) $display("FAIL rstmid_reach: saw %0d burst words, required 8", seen);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({ld_o, M_o, blk_first_o, blk_last_o, in_ready_o} !== 36'h0)
      $display("FAIL rstmid_abort: ld=%b M=%h first=%b last=%b ready=%b, required all 0",
               ld_o, M_o, blk_first_o, blk_last_o, in_ready_o);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    msg.delete();
    for (int i = 0; i < 5; i++) msg.push_back(8'($urandom));
    build_exp(); clear_cap();
    drive_msg(1'b0, ok1);
    wait_words(exp_w.size(), ok2);
    n_total++;
    if (!(ok1 && ok2) || cap_w.size() != 16) $display("FAIL rstmid_count: got %0d words, required 16", cap_w.size());
    else n_pass++;
    for (int k = 0; k < exp_w.size() && k < cap_w.size(); k++) begin
      n_total++;
      if ({cap_w[k], cap_f[k], cap_l[k]} !== {exp_w[k], exp_f[k], exp_l[k]})
        $display("FAIL rstmid_word%0d: got %h/%b/%b, required %h/%b/%b", k, cap_w[k], cap_f[k], cap_l[k], exp_w[k], exp_f[k], exp_l[k]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_empty();
    test_55_56(55);
    test_55_56(56);
    test_55_56(64);
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
